// File: rtl/clockbox_pkg.sv
// Shared types, limits and BCD helpers for the ClockBox time-of-day path.
package clockbox_pkg;

  typedef logic [7:0] bcd_t;

  typedef struct packed {
    bcd_t hours;
    bcd_t minutes;
    bcd_t seconds;
  } time_t;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } tk_state_t;

  localparam bcd_t MAX_HOURS  = 8'h23;
  localparam bcd_t MAX_MINSEC = 8'h59;

  // True when both nibbles are decimal digits and the value does not exceed max.
  function automatic logic bcd_valid(bcd_t v, bcd_t max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction

  // Two-digit BCD increment that wraps to 00 after max.
  function automatic bcd_t bcd_inc(bcd_t v, bcd_t max);
    bcd_t r;
    if (v == max)             r = '0;
    else if (v[3:0] == 4'd9)  r = {v[7:4] + 4'd1, 4'd0};
    else                      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD counter 00..MAX with synchronous load and a carry-out for chaining.
module bcd_counter2
  import clockbox_pkg::*;
#(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] value,
  output logic       carry
);

  bcd_t value_q, value_d;

  always_comb begin
    // NOTE: value_d gets a default before any branch so this block can never infer a latch.
    value_d = value_q;
    if (load)     value_d = load_val;
    else if (inc) value_d = bcd_inc(value_q, MAX);
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) value_q <= '0;
    else          value_q <= value_d;
  end

  assign value = value_q;
  assign carry = inc && (value_q == MAX);

endmodule

// File: rtl/time_keeper.sv
// ClockBox time-of-day source: prescales clock to a 1 Hz tick and keeps 24 h BCD time.
module time_keeper
  import clockbox_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] set_hours,
  input  logic [7:0] set_minutes,
  input  logic [7:0] set_seconds,
  output logic [7:0] hours,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic       tick,
  output logic       update,
  output logic       midnight,
  output logic       load_err
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  tk_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_en;
  logic             tick_q, update_q, midnight_q, load_err_q;

  time_t set_time;
  logic  load_ok, tick_evt, sec_inc;
  logic  sec_carry, min_carry, hr_carry;

  assign set_time = '{hours: set_hours, minutes: set_minutes, seconds: set_seconds};
  assign load_ok  = load && bcd_valid(set_time.hours,   MAX_HOURS)
                         && bcd_valid(set_time.minutes, MAX_MINSEC)
                         && bcd_valid(set_time.seconds, MAX_MINSEC);

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) state_q <= STOP;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      STOP:    if (run)  state_d = RUN;
      RUN:     if (!run) state_d = STOP;
      default: state_d = STOP;
    endcase
  end

  // The prescaler advances in every cycle that is (or becomes) RUN, so a
  // run level seen at an edge already counts as the first RUN cycle.
  always_comb begin
    cnt_en = (state_d == RUN);
  end

  assign tick_evt = cnt_en && (cnt_q == CNT_LAST);
  assign sec_inc  = tick_evt && !load_ok;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (load_ok || !cnt_en || tick_evt) cnt_d = '0;
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  bcd_counter2 #(.MAX(MAX_MINSEC)) u_seconds (
    .clock    (clock),
    .reset_L  (reset_L),
    .inc      (sec_inc),
    .load     (load_ok),
    .load_val (set_time.seconds),
    .value    (seconds),
    .carry    (sec_carry)
  );

  bcd_counter2 #(.MAX(MAX_MINSEC)) u_minutes (
    .clock    (clock),
    .reset_L  (reset_L),
    .inc      (sec_carry),
    .load     (load_ok),
    .load_val (set_time.minutes),
    .value    (minutes),
    .carry    (min_carry)
  );

  bcd_counter2 #(.MAX(MAX_HOURS)) u_hours (
    .clock    (clock),
    .reset_L  (reset_L),
    .inc      (min_carry),
    .load     (load_ok),
    .load_val (set_time.hours),
    .value    (hours),
    .carry    (hr_carry)
  );

  // Pulses are registered alongside the counters so they line up with the new time.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      tick_q     <= 1'b0;
      update_q   <= 1'b0;
      midnight_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      tick_q     <= sec_inc;
      update_q   <= sec_inc || load_ok;
      midnight_q <= hr_carry;
      load_err_q <= load && !load_ok;
    end
  end

  assign tick     = tick_q;
  assign update   = update_q;
  assign midnight = midnight_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: seconds-of-day reference model checked every cycle plus directed literal checks.
module tb_time_keeper;

  localparam int DIV = 4;

  logic       clock = 1'b0;
  logic       reset_L = 1'b0;
  logic       run = 1'b0;
  logic       load = 1'b0;
  logic [7:0] set_hours = '0, set_minutes = '0, set_seconds = '0;
  logic [7:0] hours, minutes, seconds;
  logic       tick, update, midnight, load_err;

  always #5 clock = ~clock;

  time_keeper #(.TICK_DIV(DIV)) dut (
    .clock       (clock),
    .reset_L     (reset_L),
    .run         (run),
    .load        (load),
    .set_hours   (set_hours),
    .set_minutes (set_minutes),
    .set_seconds (set_seconds),
    .hours       (hours),
    .minutes     (minutes),
    .seconds     (seconds),
    .tick        (tick),
    .update      (update),
    .midnight    (midnight),
    .load_err    (load_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: time as seconds since midnight, prescaler as a plain count.
  int   m_sod = 0;
  int   m_pre = 0;
  logic m_tick = 1'b0, m_upd = 1'b0, m_mid = 1'b0, m_err = 1'b0;
  bit   chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  // Decimal value of a BCD byte, or -1 when it is not a legal value <= lim.
  function automatic int bcd_val(input logic [7:0] v, input int lim);
    int hi, lo;
    hi = int'(v) / 16;
    lo = int'(v) % 16;
    if (hi > 9 || lo > 9 || hi * 10 + lo > lim) return -1;
    return hi * 10 + lo;
  endfunction

  task automatic model_reset();
    m_sod = 0; m_pre = 0;
    m_tick = 0; m_upd = 0; m_mid = 0; m_err = 0;
  endtask

  task automatic model_step();
    int  h, m, s;
    bit  valid, ev;
    h = bcd_val(set_hours, 23);
    m = bcd_val(set_minutes, 59);
    s = bcd_val(set_seconds, 59);
    valid = (h >= 0) && (m >= 0) && (s >= 0);
    ev = run && (m_pre == DIV - 1);
    m_tick = 0; m_upd = 0; m_mid = 0;
    m_err = load && !valid;
    if (load && valid) begin
      m_sod = h * 3600 + m * 60 + s;
      m_pre = 0;
      m_upd = 1;
    end else begin
      if (ev) begin
        m_sod = (m_sod + 1) % 86400;
        m_tick = 1;
        m_upd = 1;
        m_mid = (m_sod == 0);
      end
      m_pre = run ? (m_pre + 1) % DIV : 0;
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic wait_pre(input int target);
    int n = 0;
    while (m_pre != target && n < 16) begin
      cyc();
      n++;
    end
    check("prescaler_align_timeout", 32'(n < 16), 32'd1);
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("hours",    32'(hours),    32'(to_bcd(m_sod / 3600)));
      check("minutes",  32'(minutes),  32'(to_bcd((m_sod / 60) % 60)));
      check("seconds",  32'(seconds),  32'(to_bcd(m_sod % 60)));
      check("tick",     32'(tick),     32'(m_tick));
      check("update",   32'(update),   32'(m_upd));
      check("midnight", 32'(midnight), 32'(m_mid));
      check("load_err", 32'(load_err), 32'(m_err));
    end
  end

  initial begin
    int mids, ticks;

    #8;
    check("reset_outputs", 32'({hours, minutes, seconds, tick, update, midnight, load_err}), 32'd0);
    #4 reset_L = 1'b1;
    model_reset();
    chk_en = 1'b1;

    // Free run from 00:00:00: ticks on the 4th, 8th and 12th edge.
    run = 1'b1;
    repeat (3) cyc();
    check("run_no_early_tick", 32'(tick), 32'd0);
    cyc();
    check("run_tick1", 32'({tick, update}), 32'h3);
    check("run_sec1", 32'(seconds), 32'h01);
    repeat (4) cyc();
    check("run_sec2", 32'(seconds), 32'h02);
    repeat (4) cyc();
    check("run_sec3", 32'({tick, seconds}), 32'h103);

    // Asynchronous reset mid-count.
    repeat (2) cyc();
    #2 reset_L = 1'b0;
    model_reset();
    #1;
    check("async_reset", 32'({hours, minutes, seconds, tick, update, midnight, load_err}), 32'd0);
    #2 reset_L = 1'b1;
    repeat (3) cyc();
    check("post_reset_no_tick", 32'(tick), 32'd0);
    cyc();
    check("post_reset_tick", 32'({tick, seconds}), 32'h101);

    // Midnight wrap.
    set_hours = 8'h23; set_minutes = 8'h59; set_seconds = 8'h58; load = 1'b1;
    cyc();
    load = 1'b0;
    check("wrap_loaded", 32'({hours, minutes, seconds, update, tick}), 32'({24'h235958, 2'b10}));
    mids = 0;
    repeat (8) begin
      cyc();
      mids += int'(midnight);
    end
    check("wrap_midnight_once", 32'(mids), 32'd1);
    check("wrap_time", 32'({hours, minutes, seconds}), 32'h000000);

    // Invalid loads while frozen.
    run = 1'b0;
    cyc();
    set_hours = 8'h24; set_minutes = 8'h10; set_seconds = 8'h20; load = 1'b1;
    cyc();
    load = 1'b0;
    check("bad_hours", 32'({load_err, update, hours, minutes, seconds}), 32'({2'b10, 24'h000000}));
    set_hours = 8'h12; set_minutes = 8'h30; set_seconds = 8'h5A; load = 1'b1;
    cyc();
    load = 1'b0;
    check("bad_seconds", 32'({load_err, update, hours, minutes, seconds}), 32'({2'b10, 24'h000000}));
    set_hours = 8'h00; set_minutes = 8'h00; set_seconds = 8'h00; load = 1'b1;
    cyc();
    load = 1'b0;
    check("same_time_load", 32'({load_err, update}), 32'b01);

    // Valid load colliding with a tick event.
    run = 1'b1;
    wait_pre(DIV - 1);
    set_hours = 8'h12; set_minutes = 8'h34; set_seconds = 8'h56; load = 1'b1;
    cyc();
    load = 1'b0;
    check("collide_load", 32'({tick, hours, minutes, seconds}), 32'({1'b0, 24'h123456}));
    repeat (3) cyc();
    check("collide_no_tick", 32'(tick), 32'd0);
    cyc();
    check("collide_next", 32'({tick, hours, minutes, seconds}), 32'({1'b1, 24'h123457}));

    // Invalid load colliding with a tick event.
    wait_pre(DIV - 1);
    set_minutes = 8'h7B; load = 1'b1;
    cyc();
    load = 1'b0;
    check("bad_load_tick", 32'({tick, load_err, seconds}), 32'({2'b11, 8'h58}));

    // Pause at prescaler 2.
    wait_pre(2);
    run = 1'b0;
    ticks = 0;
    repeat (20) begin
      cyc();
      ticks += int'(tick);
    end
    check("pause_no_ticks", 32'(ticks), 32'd0);
    check("pause_frozen", 32'({hours, minutes, seconds}), 32'h123458);
    run = 1'b1;
    repeat (3) cyc();
    check("resume_no_tick", 32'(tick), 32'd0);
    cyc();
    check("resume_tick", 32'({tick, seconds}), 32'h159);

    // Randomized traffic against the model.
    repeat (3000) begin
      run  = ($urandom_range(0, 9) != 0);
      load = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: begin
          set_hours = to_bcd($urandom_range(0, 23));
          set_minutes = to_bcd($urandom_range(0, 59));
          set_seconds = to_bcd($urandom_range(0, 59));
        end
        1: begin
          set_hours = 8'h23; set_minutes = 8'h59;
          set_seconds = to_bcd($urandom_range(50, 59));
        end
        default: begin
          set_hours = 8'($urandom);
          set_minutes = 8'($urandom);
          set_seconds = 8'($urandom);
        end
      endcase
      cyc();
    end
    load = 1'b0;
    cyc();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
